// File: rtl/calc_pkg.sv
// Shared operation encoding for the calculator pushbutton front-end, datapath and display mux.
package calc_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned LED_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam logic [1:0] OP_OFF  = 2'd0;
    localparam logic [1:0] OP_SOMA = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MULT = 2'd3;

    // One-hot indicator {MULT,SUB,SOMA}; dark when no operation is selected.
    function automatic logic [LED_W-1:0] led_of(input op_t o);
        logic [LED_W-1:0] led;
        case (o)
            OP_SOMA: led = 3'b001;
            OP_SUB:  led = 3'b010;
            OP_MULT: led = 3'b100;
            default: led = 3'b000;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// One raw active-low key: 2-FF synchronizer, stability counter, and a one-cycle release event.
module calc_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_n,
    output logic released_pulse
);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    // The level flips on the cycle the counter would reach the threshold;
    // the release event is registered alongside so it lines up with the new level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1          <= 1'b1;
            sync2          <= 1'b1;
            level          <= 1'b1;
            cnt            <= '0;
            released_pulse <= 1'b0;
        end else begin
            sync1          <= raw_n;
            sync2          <= sync1;
            released_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
                level          <= sync2;
                cnt            <= '0;
                released_pulse <= sync2;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/calc_botoes.sv
// Calculator key front-end: four debounced release events feed the operation-select FSM
// and the compute / error command pulses.
module calc_botoes
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             botao,
    input  logic             botaoSOMA,
    input  logic             botaoSUB,
    input  logic             botaoMULT,
    output logic [OP_W-1:0]  op,
    output logic             op_valid,
    output logic [LED_W-1:0] led_op,
    output logic             calcular,
    output logic             erro
);

    logic rel_ok;
    logic rel_soma;
    logic rel_sub;
    logic rel_mult;

    op_t  op_next;
    logic calc_next;
    logic erro_next;

    calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ok (
        .clock(clock), .reset_n(reset_n), .raw_n(botao), .released_pulse(rel_ok)
    );
    calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_soma (
        .clock(clock), .reset_n(reset_n), .raw_n(botaoSOMA), .released_pulse(rel_soma)
    );
    calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sub (
        .clock(clock), .reset_n(reset_n), .raw_n(botaoSUB), .released_pulse(rel_sub)
    );
    calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mult (
        .clock(clock), .reset_n(reset_n), .raw_n(botaoMULT), .released_pulse(rel_mult)
    );

    // Confirm outranks op keys; among op keys SOMA > SUB > MULT, losers are dropped.
    always_comb begin
        op_next   = op;
        calc_next = 1'b0;
        erro_next = 1'b0;
        if (rel_ok) begin
            if (op != OP_OFF) begin
                calc_next = 1'b1;
            end else begin
                erro_next = 1'b1;
            end
        end else if (rel_soma) begin
            op_next = (op == OP_SOMA) ? OP_OFF : OP_SOMA;
        end else if (rel_sub) begin
            op_next = (op == OP_SUB) ? OP_OFF : OP_SUB;
        end else if (rel_mult) begin
            op_next = (op == OP_MULT) ? OP_OFF : OP_MULT;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op       <= OP_OFF;
            op_valid <= 1'b0;
            led_op   <= '0;
            calcular <= 1'b0;
            erro     <= 1'b0;
        end else begin
            op       <= op_next;
            op_valid <= (op_next != OP_OFF);
            led_op   <= led_of(op_next);
            calcular <= calc_next;
            erro     <= erro_next;
        end
    end

endmodule

// File: tb/tb_calc_botoes.sv
// Directed bench for calc_botoes: a scoreboard of predicted register updates checked cycle by cycle.
module tb_calc_botoes;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = N + 3;

    localparam logic [3:0] K_OK   = 4'b0001;
    localparam logic [3:0] K_SOMA = 4'b0010;
    localparam logic [3:0] K_SUB  = 4'b0100;
    localparam logic [3:0] K_MULT = 4'b1000;

    typedef struct packed {
        int         due;
        logic [1:0] op;
        logic       calc;
        logic       erro;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] keys_n = 4'b1111;
    logic [1:0] op;
    logic       op_valid;
    logic [2:0] led_op;
    logic       calcular;
    logic       erro;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         in_reset = 1'b1;
    logic [1:0] model_op = 2'd0;
    logic [1:0] cur_op = 2'd0;
    exp_t       q[$];

    calc_botoes #(.DEBOUNCE_CYCLES(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .botao(keys_n[0]), .botaoSOMA(keys_n[1]), .botaoSUB(keys_n[2]), .botaoMULT(keys_n[3]),
        .op(op), .op_valid(op_valid), .led_op(led_op), .calcular(calcular), .erro(erro)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] led_model(input logic [1:0] o);
        return (o == 2'd0) ? 3'b000 : (3'b001 << (o - 2'd1));
    endfunction

    function automatic exp_t predict(input logic [1:0] cur, input logic [3:0] ev);
        exp_t e;
        e = '0;
        e.op = cur;
        if (ev[0]) begin
            e.calc = (cur != 2'd0);
            e.erro = (cur == 2'd0);
        end else if (ev[1]) e.op = (cur == 2'd1) ? 2'd0 : 2'd1;
        else if (ev[2])     e.op = (cur == 2'd2) ? 2'd0 : 2'd2;
        else if (ev[3])     e.op = (cur == 2'd3) ? 2'd0 : 2'd3;
        return e;
    endfunction

    // Scoreboard monitor: a due entry defines the update, every other cycle must hold steady.
    always @(negedge clock) begin
        if (!in_reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                cur_op = e.op;
                check("calcular_evt", 8'(calcular), 8'(e.calc));
                check("erro_evt", 8'(erro), 8'(e.erro));
            end else begin
                check("calcular_idle", 8'(calcular), 8'd0);
                check("erro_idle", 8'(erro), 8'd0);
            end
            check("op", 8'(op), 8'(cur_op));
            check("op_valid", 8'(op_valid), 8'(cur_op != 2'd0));
            check("led_op", 8'(led_op), 8'(led_model(cur_op)));
        end
    end

    task automatic release_keys(input logic [3:0] m);
        exp_t e;
        e = predict(model_op, m);
        e.due = cyc + LAT;
        q.push_back(e);
        model_op = e.op;
        keys_n = keys_n | m;
    endtask

    task automatic tap(input logic [3:0] m, input int hold);
        @(negedge clock); #1;
        keys_n = keys_n & ~m;
        repeat (hold) @(negedge clock);
        #1;
        release_keys(m);
        repeat (12) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op"}, 8'(op), 8'd0);
        check({tag, "_op_valid"}, 8'(op_valid), 8'd0);
        check({tag, "_led_op"}, 8'(led_op), 8'd0);
        check({tag, "_calcular"}, 8'(calcular), 8'd0);
        check({tag, "_erro"}, 8'(erro), 8'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_values("rst");
        #1;
        reset_n = 1'b1;
        in_reset = 1'b0;
        repeat (2) @(negedge clock);

        // Select / toggle off / select another
        tap(K_SOMA, 10);
        tap(K_SOMA, 10);
        tap(K_MULT, 10);

        // Compute with op set, error with op cleared
        tap(K_SUB, 10);
        tap(K_OK, 10);
        tap(K_SUB, 10);
        tap(K_OK, 10);

        // Short glitch must vanish; a long hold waits for the release
        @(negedge clock); #1;
        keys_n = keys_n & ~K_SUB;
        repeat (3) @(negedge clock);
        #1;
        keys_n = keys_n | K_SUB;
        repeat (12) @(negedge clock);
        tap(K_SUB, 50);
        tap(K_SUB, 10);

        // Simultaneous releases
        tap(K_SOMA | K_MULT, 10);
        tap(K_MULT, 10);
        tap(K_OK | K_SUB, 10);

        // Asynchronous reset in the middle of a debounce
        tap(K_SUB, 10);
        @(negedge clock); #1;
        keys_n = keys_n & ~K_SUB;
        repeat (4) @(negedge clock);
        #2;
        in_reset = 1'b1;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        q.delete();
        model_op = 2'd0;
        cur_op = 2'd0;
        repeat (3) @(negedge clock);
        #1;
        reset_n = 1'b1;
        in_reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        release_keys(K_SUB);
        repeat (12) @(negedge clock);

        check("scoreboard_drained", 8'(q.size()), 8'd0);
        check("final_op", 8'(op), 8'd2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
